// File: rtl/trng_pkg.sv
// Shared types and constants for the TRNG post-processing slice.
package trng_pkg;

   typedef enum logic {
      PAIR_IDLE       = 1'b0,
      PAIR_HAVE_FIRST = 1'b1
   } pair_state_e;

   localparam int unsigned WORD_W_DEF    = 8;
   localparam int unsigned REP_LIMIT_DEF = 32;

   // Bits needed for a counter holding 0 .. n-1.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/trng_vn_extractor.sv
// Von Neumann pair extractor: one debiased bit per unequal raw pair.
// vn_bit/vn_valid are registered; vn_bit_d/vn_valid_d are their same-cycle next values.
module trng_vn_extractor
   import trng_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   input  logic random_bit,
   input  logic random_valid,
   output logic vn_bit,
   output logic vn_valid,
   output logic vn_bit_d,
   output logic vn_valid_d
);

   pair_state_e state_q, state_d;
   logic        first_q, first_d;
   logic        vn_bit_q, vn_valid_q;

   always_comb begin
      state_d    = state_q;
      first_d    = first_q;
      vn_bit_d   = 1'b0;
      vn_valid_d = 1'b0;
      if (!enable) begin
         state_d = PAIR_IDLE;
      end else if (random_valid) begin
         case (state_q)
            PAIR_IDLE: begin
               first_d = random_bit;
               state_d = PAIR_HAVE_FIRST;
            end
            PAIR_HAVE_FIRST: begin
               state_d    = PAIR_IDLE;
               vn_valid_d = first_q ^ random_bit;
               vn_bit_d   = first_q;
            end
            default: state_d = PAIR_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= PAIR_IDLE;
         first_q    <= 1'b0;
         vn_bit_q   <= 1'b0;
         vn_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         first_q    <= first_d;
         vn_bit_q   <= vn_bit_d;
         vn_valid_q <= vn_valid_d;
      end
   end

   assign vn_bit   = vn_bit_q;
   assign vn_valid = vn_valid_q;

endmodule

// File: rtl/trng_postproc.sv
// Debiases the raw TRNG stream and packs bits LSB-first into WORD_W-bit words.
// Optional repetition-count health test enabled by defining TRNG_HEALTH_EN.
module trng_postproc
   import trng_pkg::*;
#(
   parameter int unsigned WORD_W    = WORD_W_DEF,
   parameter int unsigned REP_LIMIT = REP_LIMIT_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              random_bit,
   input  logic              random_valid,
   output logic [WORD_W-1:0] word_out,
   output logic              word_valid,
   input  logic              word_ready,
   output logic              overflow,
   output logic              health_fail
);

   localparam int unsigned CW = cnt_width(WORD_W);

   if (WORD_W < 2 || REP_LIMIT < 2) begin : g_bad_param
      $error("trng_postproc: WORD_W and REP_LIMIT must both be >= 2");
   end

   logic              vn_bit, vn_valid, vn_bit_d, vn_valid_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [WORD_W-2:0] shift_q, shift_d;
   logic [WORD_W-1:0] word_q, word_d;
   logic              valid_q, valid_d, ovf_q, ovf_d;
   logic              word_done, hf_block;

   trng_vn_extractor u_vn (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .random_bit   (random_bit),
      .random_valid (random_valid),
      .vn_bit       (vn_bit),
      .vn_valid     (vn_valid),
      .vn_bit_d     (vn_bit_d),
      .vn_valid_d   (vn_valid_d)
   );

   // Bits 0..W-2 pack from the registered extractor output (debiased bits are
   // >=2 cycles apart, so this lag is always absorbed); the final bit is taken
   // from the same-cycle value so the word loads on the completing raw edge.
   always_comb begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
      if (!enable) begin
         shift_d = '0;
         cnt_d   = '0;
      end else if (vn_valid) begin
         for (int unsigned i = 0; i < WORD_W - 1; i++) begin
            if (cnt_q == CW'(i)) shift_d[i] = vn_bit;
         end
         cnt_d = (cnt_q == CW'(WORD_W - 1)) ? '0 : cnt_q + 1'b1;
      end
   end

   assign word_done = vn_valid_d && (cnt_q == CW'(WORD_W - 1));

   always_comb begin
      valid_d = valid_q;
      word_d  = word_q;
      ovf_d   = ovf_q;
      if (word_done && !hf_block) begin
         if (!valid_q || word_ready) begin
            valid_d = 1'b1;
            word_d  = {vn_bit_d, shift_q};
         end else begin
            ovf_d = 1'b1;
         end
      end else if (word_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         shift_q <= '0;
         word_q  <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         word_q  <= word_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
      end
   end

   assign word_out   = word_q;
   assign word_valid = valid_q;
   assign overflow   = ovf_q;

`ifdef TRNG_HEALTH_EN
   localparam int unsigned RW = cnt_width(REP_LIMIT + 1);

   logic [RW-1:0] run_q, run_d;
   logic          last_q, last_d, hf_q, hf_d;

   always_comb begin
      run_d  = run_q;
      last_d = last_q;
      hf_d   = hf_q;
      if (enable && random_valid) begin
         last_d = random_bit;
         if (run_q != '0 && random_bit == last_q) begin
            if (run_q != RW'(REP_LIMIT)) run_d = run_q + 1'b1;
         end else begin
            run_d = RW'(1);
         end
         if (run_d == RW'(REP_LIMIT)) hf_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q  <= '0;
         last_q <= 1'b0;
         hf_q   <= 1'b0;
      end else begin
         run_q  <= run_d;
         last_q <= last_d;
         hf_q   <= hf_d;
      end
   end

   assign hf_block    = hf_q;
   assign health_fail = hf_q;
`else
   assign hf_block    = 1'b0;
   assign health_fail = 1'b0;
`endif

endmodule

// File: tb/tb_trng_postproc.sv
// Directed bench for trng_postproc with a queue-based reference model checked every cycle.
module tb_trng_postproc;

   localparam int W   = 8;
   localparam int REP = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         enable = 1'b0;
   logic         random_bit = 1'b0;
   logic         random_valid = 1'b0;
   logic         word_ready = 1'b0;
   logic [W-1:0] word_out;
   logic         word_valid, overflow, health_fail;

   int n_cmp = 0;
   int n_bad = 0;
   bit checking = 1'b0;

   trng_postproc #(.WORD_W(W), .REP_LIMIT(REP)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .random_bit   (random_bit),
      .random_valid (random_valid),
      .word_out     (word_out),
      .word_valid   (word_valid),
      .word_ready   (word_ready),
      .overflow     (overflow),
      .health_fail  (health_fail)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: raw pairs -> debiased bit list -> words -> one-deep output slot.
   bit           m_have = 1'b0;
   bit           m_first = 1'b0;
   bit           dq[$];
   int           m_run = 0;
   bit           m_last = 1'b0;
   bit           exp_valid = 1'b0;
   logic [W-1:0] exp_word = '0;
   bit           exp_ovf = 1'b0;
   bit           exp_hf = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_have = 0; dq.delete(); m_run = 0; m_last = 0;
         exp_valid = 0; exp_word = '0; exp_ovf = 0; exp_hf = 0;
      end else begin
         bit           done;
         bit           hf_pre;
         logic [W-1:0] nw;
         done = 0; nw = '0; hf_pre = exp_hf;
         if (!enable) begin
            m_have = 0; dq.delete();
         end else if (random_valid) begin
            if (!m_have) begin
               m_first = random_bit; m_have = 1;
            end else begin
               m_have = 0;
               if (m_first != random_bit) begin
                  dq.push_back(m_first);
                  if (dq.size() == W) begin
                     done = 1;
                     foreach (dq[i]) nw[i] = dq[i];
                     dq.delete();
                  end
               end
            end
         end
`ifdef TRNG_HEALTH_EN
         if (enable && random_valid) begin
            if (m_run > 0 && random_bit == m_last) m_run++;
            else m_run = 1;
            m_last = random_bit;
            if (m_run >= REP) exp_hf = 1;
         end
`endif
         if (done && !hf_pre && (!exp_valid || word_ready)) begin
            exp_valid = 1; exp_word = nw;
         end else begin
            if (done && !hf_pre) exp_ovf = 1;
            if (word_ready) exp_valid = 0;
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (checking) begin
         check("cyc word_valid", 32'(word_valid), 32'(exp_valid));
         check("cyc word_out", 32'(word_out), 32'(exp_word));
         check("cyc overflow", 32'(overflow), 32'(exp_ovf));
         check("cyc health_fail", 32'(health_fail), 32'(exp_hf));
      end
   end

   logic [W-1:0] hs[$];
   always @(posedge clk) if (rst_n && word_valid && word_ready) hs.push_back(word_out);

   task automatic raw(input logic b);
      @(negedge clk);
      random_bit = b; random_valid = 1'b1;
   endtask

   task automatic pair(input logic a, input logic b);
      raw(a); raw(b);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk) random_valid = 1'b0;
   endtask

   task automatic send_word(input logic [W-1:0] w, input bit junk);
      for (int i = 0; i < W; i++) begin
         if (junk) begin pair(1'b0, 1'b0); pair(1'b1, 1'b1); end
         if (w[i]) pair(1'b1, 1'b0); else pair(1'b0, 1'b1);
      end
   endtask

   task automatic do_reset;
      @(negedge clk); random_valid = 1'b0; rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
   endtask

   function automatic logic [31:0] hs_at(input int i);
      return (hs.size() > i) ? 32'(hs[i]) : 32'hDEAD;
   endfunction

   initial begin
      logic [W-1:0] w22;
      w22 = 8'h22;
      @(posedge clk); checking = 1'b1;
      @(negedge clk);
      check("reset word_valid", 32'(word_valid), 0);
      check("reset word_out", 32'(word_out), 0);
      check("reset overflow", 32'(overflow), 0);
      check("reset health_fail", 32'(health_fail), 0);
      rst_n = 1'b1; enable = 1'b1; word_ready = 1'b1;

      // Pack 8'hA5
      send_word(8'hA5, 0); idle(4);
      check("a5 count", hs.size(), 1);
      check("a5 word", hs_at(0), 32'hA5);
      check("a5 overflow", 32'(overflow), 0);
      hs.delete();

      // Equal pairs discarded
      send_word(8'hA5, 1); idle(4);
      check("junk count", hs.size(), 1);
      check("junk word", hs_at(0), 32'hA5);
      hs.delete();

      // Backpressure and drop
      @(negedge clk) word_ready = 1'b0;
      send_word(8'h01, 0); send_word(8'hFF, 0); idle(2);
      check("bp valid", 32'(word_valid), 1);
      check("bp word", 32'(word_out), 32'h01);
      check("bp overflow", 32'(overflow), 1);
      @(negedge clk) word_ready = 1'b1;
      idle(2);
      check("bp drained", 32'(word_valid), 0);
      check("bp count", hs.size(), 1);
      check("bp only 01", hs_at(0), 32'h01);
      hs.delete();

      // Enable flush discards a partial word
      pair(1, 0); pair(0, 1); pair(1, 0); pair(1, 0); pair(0, 1);
      @(negedge clk) begin enable = 1'b0; random_valid = 1'b0; end
      @(negedge clk) enable = 1'b1;
      send_word(8'h3C, 0); idle(4);
      check("flush count", hs.size(), 1);
      check("flush word", hs_at(0), 32'h3C);
      hs.delete();

      // Load on the same edge as consume
      do_reset();
      word_ready = 1'b0;
      send_word(8'h11, 0);
      for (int i = 0; i < W - 1; i++) begin
         if (w22[i]) pair(1'b1, 1'b0); else pair(1'b0, 1'b1);
      end
      raw(1'b0);
      @(negedge clk) begin random_bit = 1'b1; random_valid = 1'b1; word_ready = 1'b1; end
      @(posedge clk); #1;
      check("simul valid", 32'(word_valid), 1);
      check("simul word", 32'(word_out), 32'h22);
      check("simul overflow", 32'(overflow), 0);
      idle(3);
      check("simul count", hs.size(), 2);
      check("simul first", hs_at(0), 32'h11);
      check("simul second", hs_at(1), 32'h22);
      hs.delete();

      // Asynchronous reset mid-word with a pending output
      word_ready = 1'b0;
      send_word(8'h5A, 0);
      pair(1, 0); pair(0, 1); raw(1);
      @(posedge clk); #3;
      rst_n = 1'b0; random_valid = 1'b0;
      #1;
      check("areset valid", 32'(word_valid), 0);
      check("areset word", 32'(word_out), 0);
      check("areset overflow", 32'(overflow), 0);
      @(negedge clk) begin rst_n = 1'b1; word_ready = 1'b1; end
      send_word(8'hC3, 0); idle(4);
      check("post reset count", hs.size(), 1);
      check("post reset word", hs_at(0), 32'hC3);
      hs.delete();

`ifdef TRNG_HEALTH_EN
      do_reset();
      repeat (31) raw(1'b1);
      check("hf before limit", 32'(health_fail), 0);
      raw(1'b1);
      @(posedge clk); #1;
      check("hf at limit", 32'(health_fail), 1);
      idle(1);
      send_word(8'hA5, 0); idle(4);
      check("hf no words", hs.size(), 0);
      check("hf no overflow", 32'(overflow), 0);
      @(negedge clk) rst_n = 1'b0;
      #1;
      check("hf reset clears", 32'(health_fail), 0);
      check("hf reset valid", 32'(word_valid), 0);
      @(negedge clk) rst_n = 1'b1;
      idle(2);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      n_bad++;
      $display("FAIL timeout: bench did not complete, got running expected finished");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
